// File: rtl/banked_regfile.sv
// banked_regfile: ARM banked general-purpose register file with per-mode
// SPSR bank and atomic exception entry (LR_mode + SPSR_mode in one cycle).
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   mode, usr_bank       current CPSR mode; usr_bank forces USR mapping on
//                        the read and write ports
//   rd_addr / rd_data    RD_PORTS combinational read ports (packed, port p
//                        at [4p+3:4p] / [DATA_W*p +: DATA_W])
//   we, wr_addr, wr_data GPR write port
//   spsr_we, spsr_wd     SPSR write for the current mode (ignored in USR/SYS)
//   spsr_rd              SPSR of the current mode (0 in USR/SYS/illegal)
//   exc_req, exc_mode,   exception entry: R14 of exc_mode <= exc_lr,
//   exc_lr, cpsr_in      SPSR of exc_mode <= cpsr_in
//   exc_ack              one-cycle pulse after an exception write commits
//   mode_err             illegal mode / illegal exception target seen
module banked_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RD_PORTS = 3,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [4:0]                   mode,
  input  logic                         usr_bank,
  input  logic [4*RD_PORTS-1:0]        rd_addr,
  output logic [DATA_W*RD_PORTS-1:0]   rd_data,
  input  logic                         we,
  input  logic [3:0]                   wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         spsr_we,
  input  logic [DATA_W-1:0]            spsr_wd,
  output logic [DATA_W-1:0]            spsr_rd,
  input  logic                         exc_req,
  input  logic [4:0]                   exc_mode,
  input  logic [DATA_W-1:0]            exc_lr,
  input  logic [DATA_W-1:0]            cpsr_in,
  output logic                         exc_ack,
  output logic                         mode_err
);

  typedef enum logic [4:0] {
    M_USR = 5'b10000,
    M_FIQ = 5'b10001,
    M_IRQ = 5'b10010,
    M_SVC = 5'b10011,
    M_ABT = 5'b10111,
    M_UND = 5'b11011,
    M_SYS = 5'b11111
  } mode_e;

  localparam int unsigned NPHYS = 31;
  localparam int unsigned NSPSR = 5;

  // Logical register + mode -> physical index. Illegal modes map like USR.
  function automatic logic [4:0] phys_map(input logic [3:0] r, input logic [4:0] m);
    logic [4:0] p;
    logic       hi;
    p  = {1'b0, r};
    hi = (r == 4'd13) || (r == 4'd14);
    case (m)
      M_FIQ: if (r >= 4'd8 && r != 4'd15) p = 5'd8 + {1'b0, r};
      M_SVC: if (hi) p = 5'd23 + {4'b0, ~r[0]};
      M_ABT: if (hi) p = 5'd25 + {4'b0, ~r[0]};
      M_IRQ: if (hi) p = 5'd27 + {4'b0, ~r[0]};
      M_UND: if (hi) p = 5'd29 + {4'b0, ~r[0]};
      default: ;
    endcase
    return p;
  endfunction

  function automatic logic mode_legal(input logic [4:0] m);
    logic ok;
    case (m)
      M_USR, M_FIQ, M_IRQ, M_SVC, M_ABT, M_UND, M_SYS: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Modes that own an SPSR and a banked R14 (legal exception targets).
  function automatic logic mode_banked(input logic [4:0] m);
    logic ok;
    case (m)
      M_FIQ, M_IRQ, M_SVC, M_ABT, M_UND: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] spsr_index(input logic [4:0] m);
    logic [2:0] i;
    case (m)
      M_FIQ:   i = 3'd0;
      M_SVC:   i = 3'd1;
      M_ABT:   i = 3'd2;
      M_IRQ:   i = 3'd3;
      M_UND:   i = 3'd4;
      default: i = 3'd0;
    endcase
    return i;
  endfunction

  logic [DATA_W-1:0] gpr  [NPHYS];
  logic [DATA_W-1:0] spsr [NSPSR];

  logic [4:0] acc_mode;
  logic [4:0] wr_phys;
  logic [4:0] exc_phys;
  logic [4:0] rd_phys [RD_PORTS];
  logic       exc_ok;
  logic       cur_banked;
  logic [2:0] cur_spsr;
  logic [2:0] exc_spsr;

  always_comb begin
    acc_mode   = usr_bank ? M_USR : mode;
    wr_phys    = phys_map(wr_addr, acc_mode);
    exc_phys   = phys_map(4'd14, exc_mode);
    exc_ok     = exc_req && mode_banked(exc_mode);
    cur_banked = mode_banked(mode);
    cur_spsr   = spsr_index(mode);
    exc_spsr   = spsr_index(exc_mode);
  end

  always_comb begin
    for (int unsigned p = 0; p < RD_PORTS; p++)
      rd_phys[p] = phys_map(rd_addr[p*4 +: 4], acc_mode);
  end

  // Forwarding mirrors the commit priority (exception over we) and is
  // suppressed while reset holds, since no write can commit then.
  always_comb begin
    rd_data = '0;
    for (int unsigned p = 0; p < RD_PORTS; p++) begin
      rd_data[p*DATA_W +: DATA_W] = gpr[rd_phys[p]];
      if (BYPASS != 0 && !rst) begin
        if (exc_ok && rd_phys[p] == exc_phys)
          rd_data[p*DATA_W +: DATA_W] = exc_lr;
        else if (we && rd_phys[p] == wr_phys)
          rd_data[p*DATA_W +: DATA_W] = wr_data;
      end
    end
  end

  always_comb begin
    spsr_rd = '0;
    if (cur_banked) spsr_rd = spsr[cur_spsr];
  end

  // Exception writes are issued after the normal writes so that, on a
  // collision at the same entry, the exception value is the one kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NPHYS; i++) gpr[i[4:0]] <= '0;
      for (int unsigned i = 0; i < NSPSR; i++) spsr[i[2:0]] <= '0;
      exc_ack  <= 1'b0;
      mode_err <= 1'b0;
    end else begin
      if (we) gpr[wr_phys] <= wr_data;
      if (spsr_we && cur_banked) spsr[cur_spsr] <= spsr_wd;
      if (exc_ok) begin
        gpr[exc_phys]  <= exc_lr;
        spsr[exc_spsr] <= cpsr_in;
      end
      exc_ack  <= exc_ok;
      mode_err <= !mode_legal(mode) || (exc_req && !mode_banked(exc_mode));
    end
  end

endmodule

// File: tb/tb_banked_regfile.sv
// tb_banked_regfile: directed self-checking bench. Two instances share all
// stimulus: dut_b with forwarding (BYPASS=1) and dut_n without (BYPASS=0).
module tb_banked_regfile;

  localparam logic [4:0] USR = 5'b10000;
  localparam logic [4:0] FIQ = 5'b10001;
  localparam logic [4:0] IRQ = 5'b10010;
  localparam logic [4:0] SVC = 5'b10011;
  localparam logic [4:0] ABT = 5'b10111;
  localparam logic [4:0] UND = 5'b11011;
  localparam logic [4:0] SYS = 5'b11111;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mode;
  logic        usr_bank;
  logic [11:0] rd_addr;
  logic [95:0] rd_b, rd_n;
  logic        we;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        spsr_we;
  logic [31:0] spsr_wd;
  logic [31:0] spsr_b, spsr_n;
  logic        exc_req;
  logic [4:0]  exc_mode;
  logic [31:0] exc_lr;
  logic [31:0] cpsr_in;
  logic        ack_b, ack_n, merr_b, merr_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  banked_regfile #(.DATA_W(32), .RD_PORTS(3), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .usr_bank(usr_bank),
    .rd_addr(rd_addr), .rd_data(rd_b),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .spsr_we(spsr_we), .spsr_wd(spsr_wd), .spsr_rd(spsr_b),
    .exc_req(exc_req), .exc_mode(exc_mode), .exc_lr(exc_lr), .cpsr_in(cpsr_in),
    .exc_ack(ack_b), .mode_err(merr_b)
  );

  banked_regfile #(.DATA_W(32), .RD_PORTS(3), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .mode(mode), .usr_bank(usr_bank),
    .rd_addr(rd_addr), .rd_data(rd_n),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .spsr_we(spsr_we), .spsr_wd(spsr_wd), .spsr_rd(spsr_n),
    .exc_req(exc_req), .exc_mode(exc_mode), .exc_lr(exc_lr), .cpsr_in(cpsr_in),
    .exc_ack(ack_n), .mode_err(merr_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference map written as a bank-start table per mode.
  function automatic int ref_phys(input int r, input logic [4:0] m);
    int first, base;
    first = 16; base = 0;
    case (m)
      FIQ: begin first = 8;  base = 16; end
      SVC: begin first = 13; base = 23; end
      ABT: begin first = 13; base = 25; end
      IRQ: begin first = 13; base = 27; end
      UND: begin first = 13; base = 29; end
      default: ;
    endcase
    if (r == 15 || r < first) return r;
    return base + r - first;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; spsr_we = 1'b0; exc_req = 1'b0; usr_bank = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] m, input logic [3:0] r, input logic [31:0] v);
    mode = m; we = 1'b1; wr_addr = r; wr_data = v;
    tick();
    we = 1'b0;
  endtask

  task automatic rd0(input string tag, input logic [3:0] r, input logic [31:0] exp);
    rd_addr[3:0] = r;
    #1;
    check({tag, " byp"}, rd_b[31:0], exp);
    check({tag, " nob"}, rd_n[31:0], exp);
  endtask

  // Reads all 16 logical registers on all ports (port p offset by p).
  task automatic read_all(input logic [4:0] m, input bit zero);
    logic [3:0]  a;
    logic [31:0] exp;
    mode = m;
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < 3; p++) rd_addr[p*4 +: 4] = 4'(r + p);
      #1;
      for (int p = 0; p < 3; p++) begin
        a   = rd_addr[p*4 +: 4];
        exp = zero ? 32'h0 : 32'h100 + 32'(ref_phys(int'(a), m));
        check($sformatf("map m%b r%0d p%0d byp", m, a, p), rd_b[p*32 +: 32], exp);
        check($sformatf("map m%b r%0d p%0d nob", m, a, p), rd_n[p*32 +: 32], exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] modes [7];
    modes = '{USR, FIQ, IRQ, SVC, ABT, UND, SYS};

    rst = 1'b1; mode = USR; rd_addr = '0; wr_addr = '0; wr_data = '0;
    spsr_wd = '0; exc_mode = USR; exc_lr = '0; cpsr_in = '0;
    idle();
    #3;
    check("reset rd0", rd_b[31:0], 32'h0);
    check("reset ack", {31'b0, ack_b}, 32'h0);
    check("reset merr", {31'b0, merr_b}, 32'h0);
    mode = FIQ; #1;
    check("reset spsr", spsr_b, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Mapping sweep: every mode writes 0x100+phys to every logical register.
    for (int i = 0; i < 7; i++)
      for (int r = 0; r < 16; r++)
        do_write(modes[i], 4'(r), 32'h100 + 32'(ref_phys(r, modes[i])));
    for (int i = 0; i < 7; i++) read_all(modes[i], 1'b0);
    mode = SVC; rd0("svc r13 phys23", 4'd13, 32'h117);
    mode = FIQ; rd0("fiq r8 banked", 4'd8, 32'h110);
    mode = USR; rd0("usr r8", 4'd8, 32'h108);

    // SPSR bank: FIQ write sticks, USR write ignored and reads 0.
    mode = FIQ; spsr_we = 1'b1; spsr_wd = 32'hF1F1; tick();
    mode = USR; spsr_wd = 32'h1234; tick();
    spsr_we = 1'b0; #1;
    check("spsr usr zero", spsr_b, 32'h0);
    mode = FIQ; #1;
    check("spsr fiq", spsr_b, 32'hF1F1);

    // Bypass: same-cycle write to R3.
    mode = USR; rd_addr = 12'h0; rd_addr[3:0] = 4'd3;
    we = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF; #1;
    check("bypass same cycle byp", rd_b[31:0], 32'hDEADBEEF);
    check("bypass same cycle nob", rd_n[31:0], 32'h103);
    tick(); we = 1'b0; #1;
    check("bypass next cycle nob", rd_n[31:0], 32'hDEADBEEF);

    // Exception entry to IRQ from USR.
    mode = USR; exc_req = 1'b1; exc_mode = IRQ; exc_lr = 32'h1C; cpsr_in = 32'h10;
    tick(); exc_req = 1'b0;
    check("exc ack byp", {31'b0, ack_b}, 32'h1);
    check("exc ack nob", {31'b0, ack_n}, 32'h1);
    check("exc merr", {31'b0, merr_b}, 32'h0);
    rd0("exc usr r14 kept", 4'd14, 32'h10E);
    mode = IRQ;
    rd0("exc irq r14", 4'd14, 32'h1C);
    check("exc spsr irq", spsr_b, 32'h10);
    tick();
    check("exc ack one cycle", {31'b0, ack_b}, 32'h0);

    // Collision on SVC R14 and SPSR_svc: exception wins.
    mode = SVC; rd_addr[3:0] = 4'd14;
    we = 1'b1; wr_addr = 4'd14; wr_data = 32'h5;
    spsr_we = 1'b1; spsr_wd = 32'h99;
    exc_req = 1'b1; exc_mode = SVC; exc_lr = 32'h8; cpsr_in = 32'h13; #1;
    check("coll fwd byp", rd_b[31:0], 32'h8);
    check("coll fwd nob", rd_n[31:0], 32'h118);
    tick(); idle();
    rd0("coll svc r14", 4'd14, 32'h8);
    check("coll spsr svc", spsr_b, 32'h13);
    check("coll ack", {31'b0, ack_b}, 32'h1);

    // Different targets: both commit.
    mode = SVC;
    we = 1'b1; wr_addr = 4'd14; wr_data = 32'h5;
    spsr_we = 1'b1; spsr_wd = 32'h55;
    exc_req = 1'b1; exc_mode = ABT; exc_lr = 32'h8; cpsr_in = 32'h17; #1;
    check("split fwd byp", rd_b[31:0], 32'h5);
    tick(); idle();
    rd0("split svc r14", 4'd14, 32'h5);
    check("split spsr svc", spsr_b, 32'h55);
    mode = ABT;
    rd0("split abt r14", 4'd14, 32'h8);
    check("split spsr abt", spsr_b, 32'h17);

    // usr_bank override on read and write.
    mode = FIQ; usr_bank = 1'b1;
    rd0("ub fiq r10 usr", 4'd10, 32'h10A);
    usr_bank = 1'b0;
    rd0("ub off fiq r10", 4'd10, 32'h112);
    usr_bank = 1'b1; do_write(FIQ, 4'd10, 32'hAAAA); usr_bank = 1'b0;
    mode = USR; rd0("ub wr usr r10", 4'd10, 32'hAAAA);
    mode = FIQ; rd0("ub wr fiq r10", 4'd10, 32'h112);

    // Illegal exception target (SYS): no write, no ack, mode_err.
    mode = USR; exc_req = 1'b1; exc_mode = SYS; exc_lr = 32'h77; cpsr_in = 32'h99;
    tick(); exc_req = 1'b0;
    check("sys exc ack", {31'b0, ack_b}, 32'h0);
    check("sys exc merr", {31'b0, merr_b}, 32'h1);
    check("sys exc merr nob", {31'b0, merr_n}, 32'h1);
    rd0("sys exc r14 kept", 4'd14, 32'h10E);
    tick();
    check("merr clears", {31'b0, merr_b}, 32'h0);

    // Illegal current mode: maps like USR, SPSR reads 0, mode_err set.
    mode = 5'b00000; tick();
    check("bad mode merr", {31'b0, merr_b}, 32'h1);
    check("bad mode spsr", spsr_b, 32'h0);
    rd0("bad mode r14", 4'd14, 32'h10E);
    mode = USR; tick();

    // Async reset right after an exception commits.
    mode = IRQ; rd_addr = {4'd10, 4'd3, 4'd14};
    exc_req = 1'b1; exc_mode = UND; exc_lr = 32'h44; cpsr_in = 32'h1B;
    tick(); exc_req = 1'b0;
    check("pre-rst ack", {31'b0, ack_b}, 32'h1);
    check("pre-rst irq r14", rd_b[31:0], 32'h1C);
    #2 rst = 1'b1;
    #1;
    check("async rst ack byp", {31'b0, ack_b}, 32'h0);
    check("async rst ack nob", {31'b0, ack_n}, 32'h0);
    check("async rst spsr", spsr_b, 32'h0);
    check("async rst p0", rd_b[31:0], 32'h0);
    check("async rst p1", rd_b[63:32], 32'h0);
    check("async rst p2", rd_n[95:64], 32'h0);
    read_all(UND, 1'b1);

    // Write in the cycle reset releases is kept.
    mode = USR; we = 1'b1; wr_addr = 4'd5; wr_data = 32'h55AA;
    @(negedge clk); rst = 1'b0;
    tick(); we = 1'b0;
    rd0("post-rst write", 4'd5, 32'h55AA);
    check("post-rst ack", {31'b0, ack_b}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
